// File: rtl/pa_lsu_sram_pkg.sv
// Shared types and constants for the LSU 128x42 single-port SRAM controller.
package pa_lsu_sram_pkg;

   localparam int ADDR_WIDTH = 7;
   localparam int DATA_WIDTH = 42;
   localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [DATA_WIDTH-1:0] wmask;
   } req_t;

endpackage

// File: rtl/pa_spsram_128x42_ctrl_if.sv
// Requester-side bus of the SRAM controller: init control, two request ports, read return.
interface pa_spsram_128x42_ctrl_if;
   import pa_lsu_sram_pkg::*;

   logic                  inv_all_req;
   logic                  init_busy;
   logic                  p0_req;
   logic                  p0_wr;
   logic [ADDR_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0] p0_wdata;
   logic [DATA_WIDTH-1:0] p0_wmask;
   logic                  p0_gnt;
   logic                  p1_req;
   logic                  p1_wr;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic [DATA_WIDTH-1:0] p1_wmask;
   logic                  p1_gnt;
   logic                  rd_vld;
   logic                  rd_src;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output inv_all_req, p0_req, p0_wr, p0_addr, p0_wdata, p0_wmask,
             p1_req, p1_wr, p1_addr, p1_wdata, p1_wmask,
      input  init_busy, p0_gnt, p1_gnt, rd_vld, rd_src, rd_data
   );

   modport slave (
      input  inv_all_req, p0_req, p0_wr, p0_addr, p0_wdata, p0_wmask,
             p1_req, p1_wr, p1_addr, p1_wdata, p1_wmask,
      output init_busy, p0_gnt, p1_gnt, rd_vld, rd_src, rd_data
   );

endinterface

// File: rtl/pa_spsram_arb2.sv
// Two-way arbiter: p0 wins by default, p1 wins once after STARVE_LIM consecutive losses.
module pa_spsram_arb2
   import pa_lsu_sram_pkg::*;
#(
   parameter int STARVE_LIM = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic p0_req,
   input  logic p1_req,
   input  req_t p0_in,
   input  req_t p1_in,
   output logic p0_gnt,
   output logic p1_gnt,
   output logic sel_vld,
   output req_t sel
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   assign starved = (starve_cnt >= CW'(STARVE_LIM));

   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (en) begin
         if (p1_req && (!p0_req || starved)) begin
            p1_gnt = 1'b1;
         end else if (p0_req) begin
            p0_gnt = 1'b1;
         end
      end
   end

   assign sel_vld = p0_gnt | p1_gnt;
   assign sel     = p1_gnt ? p1_in : p0_in;

   // Counts only losses where p1 was actually waiting; idle cycles leave it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (p1_gnt) begin
         starve_cnt <= '0;
      end else if (p0_gnt && p1_req) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pa_spsram_128x42_ctrl.sv
// LSU 128x42 SRAM access controller: zeroing sweep, two-port arbitration, tagged read return.
module pa_spsram_128x42_ctrl
   import pa_lsu_sram_pkg::*;
#(
   parameter int STARVE_LIM = 4
)(
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   pa_spsram_128x42_ctrl_if.slave bus,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic                  init_busy_q;
   logic                  rd_vld_q;
   logic                  rd_src_q;
   logic                  arb_en;
   logic                  p0_gnt;
   logic                  p1_gnt;
   logic                  sel_vld;
   req_t                  p0_in;
   req_t                  p1_in;
   req_t                  sel;

   assign p0_in = '{wr: bus.p0_wr, addr: bus.p0_addr, wdata: bus.p0_wdata, wmask: bus.p0_wmask};
   assign p1_in = '{wr: bus.p1_wr, addr: bus.p1_addr, wdata: bus.p1_wdata, wmask: bus.p1_wmask};

   // An init request in IDLE steals the port for that cycle; no grants while in reset.
   assign arb_en = (state == IDLE) && !bus.inv_all_req && !cpurst;

   pa_spsram_arb2 #(
      .STARVE_LIM (STARVE_LIM)
   ) u_arb (
      .clk     (forever_cpuclk),
      .rst     (cpurst),
      .en      (arb_en),
      .p0_req  (bus.p0_req),
      .p1_req  (bus.p1_req),
      .p0_in   (p0_in),
      .p1_in   (p1_in),
      .p0_gnt  (p0_gnt),
      .p1_gnt  (p1_gnt),
      .sel_vld (sel_vld),
      .sel     (sel)
   );

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state       <= INIT;
         sweep_cnt   <= '0;
         init_busy_q <= 1'b1;
         rd_vld_q    <= 1'b0;
         rd_src_q    <= 1'b0;
      end else begin
         rd_vld_q <= sel_vld && !sel.wr;
         if (sel_vld && !sel.wr) begin
            rd_src_q <= p1_gnt;
         end
         if (state == INIT) begin
            if (sweep_cnt == LAST_ENTRY) begin
               state       <= IDLE;
               sweep_cnt   <= '0;
               init_busy_q <= 1'b0;
            end else begin
               sweep_cnt <= sweep_cnt + 1'b1;
            end
         end else if (bus.inv_all_req) begin
            state       <= INIT;
            init_busy_q <= 1'b1;
         end
      end
   end

   // The sweep writes zero through a fully enabled mask; otherwise the granted request drives the port.
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (state == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = sweep_cnt;
      end else if (sel_vld) begin
         sram_cen = 1'b0;
         sram_a   = sel.addr;
         if (sel.wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~sel.wmask;
            sram_d    = sel.wdata;
         end
      end
   end

   assign bus.init_busy = init_busy_q;
   assign bus.p0_gnt    = p0_gnt;
   assign bus.p1_gnt    = p1_gnt;
   assign bus.rd_vld    = rd_vld_q;
   assign bus.rd_src    = rd_src_q;
   assign bus.rd_data   = sram_q;

endmodule

// File: tb/tb_pa_spsram_128x42_ctrl.sv
// Bench for the LSU SRAM controller: behavioural SRAM, reference model, vector table and corner sequences.
module tb_pa_spsram_128x42_ctrl;
   import pa_lsu_sram_pkg::*;

   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int NENT = 1 << AW;
   localparam int STARVE_LIM = 4;
   localparam logic [DW-1:0] ALL = '1;
   localparam logic [DW-1:0] ZD = '0;
   localparam logic [DW-1:0] M8 = 42'h0FF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   pa_spsram_128x42_ctrl_if bus();

   always #5 clk = ~clk;

   pa_spsram_128x42_ctrl #(.STARVE_LIM(STARVE_LIM)) dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .bus            (bus),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   // Behavioural stand-in for the 128x42 SRAM macro (active-low controls, Q valid next cycle).
   logic [DW-1:0] sram_mem [NENT];
   always_ff @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) begin
            sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         end else begin
            sram_q <= sram_mem[sram_a];
         end
      end
   end

   int chk_cnt = 0;
   int pass_cnt = 0;

   // Reference model: remaining sweep cycles, consecutive p1 losses, expected memory contents.
   int            m_init_left = 0;
   int            m_losses = 0;
   logic [DW-1:0] m_mem [NENT];
   logic          m_rd_vld = 1'b0;
   logic          m_rd_src = 1'b0;
   logic [DW-1:0] m_rd_data = '0;
   logic          e_busy, e_g0, e_g1, e_cen, e_gwen, e_wr;
   logic [AW-1:0] e_a, e_addr;
   logic [DW-1:0] e_wen, e_d, e_wdata, e_wmask;

   typedef struct {
      logic          inv;
      logic          p0_req;
      logic          p0_wr;
      logic [AW-1:0] p0_addr;
      logic [DW-1:0] p0_wdata;
      logic [DW-1:0] p0_wmask;
      logic          p1_req;
      logic          p1_wr;
      logic [AW-1:0] p1_addr;
      logic [DW-1:0] p1_wdata;
      logic [DW-1:0] p1_wmask;
      logic          x_g0;
      logic          x_g1;
      logic          x_cen;
      logic          x_gwen;
      logic [AW-1:0] x_a;
      logic [DW-1:0] x_wen;
      logic [DW-1:0] x_d;
      logic          x_rvld;
      logic          x_rsrc;
      logic [DW-1:0] x_rdata;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic setIdle();
      bus.inv_all_req = 1'b0;
      bus.p0_req = 1'b0;
      bus.p0_wr = 1'b0;
      bus.p0_addr = '0;
      bus.p0_wdata = '0;
      bus.p0_wmask = '0;
      bus.p1_req = 1'b0;
      bus.p1_wr = 1'b0;
      bus.p1_addr = '0;
      bus.p1_wdata = '0;
      bus.p1_wmask = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.inv_all_req = v.inv;
      bus.p0_req = v.p0_req;
      bus.p0_wr = v.p0_wr;
      bus.p0_addr = v.p0_addr;
      bus.p0_wdata = v.p0_wdata;
      bus.p0_wmask = v.p0_wmask;
      bus.p1_req = v.p1_req;
      bus.p1_wr = v.p1_wr;
      bus.p1_addr = v.p1_addr;
      bus.p1_wdata = v.p1_wdata;
      bus.p1_wmask = v.p1_wmask;
   endtask

   task automatic applyRandom();
      bus.inv_all_req = ($urandom_range(63) == 0);
      bus.p0_req = ($urandom_range(99) < 60);
      bus.p0_wr = $urandom_range(1) == 1;
      bus.p0_addr = AW'($urandom_range(15));
      bus.p0_wdata = DW'({$urandom(), $urandom()});
      bus.p0_wmask = ($urandom_range(3) == 0) ? ALL : DW'({$urandom(), $urandom()});
      bus.p1_req = ($urandom_range(99) < 60);
      bus.p1_wr = $urandom_range(1) == 1;
      bus.p1_addr = AW'($urandom_range(15));
      bus.p1_wdata = DW'({$urandom(), $urandom()});
      bus.p1_wmask = ($urandom_range(3) == 0) ? ALL : DW'({$urandom(), $urandom()});
   endtask

   task automatic modelEval();
      e_busy = (m_init_left > 0);
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      e_cen = 1'b1;
      e_gwen = 1'b1;
      e_a = '0;
      e_wen = ALL;
      e_d = ZD;
      e_wr = 1'b0;
      e_addr = '0;
      e_wdata = ZD;
      e_wmask = ZD;
      if (e_busy) begin
         e_cen = 1'b0;
         e_gwen = 1'b0;
         e_wen = ZD;
         e_a = AW'(NENT - m_init_left);
      end else if (!bus.inv_all_req && !rst) begin
         if (bus.p1_req && (!bus.p0_req || m_losses >= STARVE_LIM)) e_g1 = 1'b1;
         else if (bus.p0_req) e_g0 = 1'b1;
         if (e_g0 || e_g1) begin
            e_wr = e_g1 ? bus.p1_wr : bus.p0_wr;
            e_addr = e_g1 ? bus.p1_addr : bus.p0_addr;
            e_wdata = e_g1 ? bus.p1_wdata : bus.p0_wdata;
            e_wmask = e_g1 ? bus.p1_wmask : bus.p0_wmask;
            e_cen = 1'b0;
            e_a = e_addr;
            if (e_wr) begin
               e_gwen = 1'b0;
               e_wen = ~e_wmask;
               e_d = e_wdata;
            end
         end
      end
   endtask

   task automatic modelCheck();
      checkOutput("init_busy", 64'(bus.init_busy), 64'(e_busy));
      checkOutput("p0_gnt", 64'(bus.p0_gnt), 64'(e_g0));
      checkOutput("p1_gnt", 64'(bus.p1_gnt), 64'(e_g1));
      checkOutput("sram_cen", 64'(sram_cen), 64'(e_cen));
      checkOutput("sram_gwen", 64'(sram_gwen), 64'(e_gwen));
      checkOutput("sram_a", 64'(sram_a), 64'(e_a));
      checkOutput("sram_wen", 64'(sram_wen), 64'(e_wen));
      checkOutput("sram_d", 64'(sram_d), 64'(e_d));
      checkOutput("rd_vld", 64'(bus.rd_vld), 64'(m_rd_vld));
      if (m_rd_vld) begin
         checkOutput("rd_src", 64'(bus.rd_src), 64'(m_rd_src));
         checkOutput("rd_data", 64'(bus.rd_data), 64'(m_rd_data));
      end
   endtask

   task automatic modelStep();
      if (rst) begin
         if (e_busy) m_mem[e_a] = ZD;
         m_init_left = NENT;
         m_losses = 0;
         m_rd_vld = 1'b0;
         m_rd_src = 1'b0;
      end else begin
         m_rd_vld = 1'b0;
         if (e_busy) begin
            m_mem[e_a] = ZD;
            m_init_left--;
         end else if (bus.inv_all_req) begin
            m_init_left = NENT;
         end else if (e_g0 || e_g1) begin
            if (e_wr) begin
               m_mem[e_addr] = (m_mem[e_addr] & ~e_wmask) | (e_wdata & e_wmask);
            end else begin
               m_rd_vld = 1'b1;
               m_rd_src = e_g1;
               m_rd_data = m_mem[e_addr];
            end
         end
         if (!e_busy && !bus.inv_all_req) begin
            if (e_g1) m_losses = 0;
            else if (bus.p1_req) m_losses++;
         end
      end
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      modelEval();
      if (!rst) modelCheck();
   endtask

   task automatic finishCycle();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busy_n;
      int gnt_in_init;
      int ones;
      int streak;
      int max_streak;
      int vld_n;
      int nz_n;
      int seen [NENT];

      vecs[0]  = '{1'b0, 1'b1, 1'b1, 7'd5, ALL, ALL, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b1, 1'b0, 1'b0, 1'b0, 7'd5, ZD, ALL, 1'b0, 1'b0, ZD};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b1, 1'b0, 7'd5, ZD, ZD,
                   1'b0, 1'b1, 1'b0, 1'b1, 7'd5, ALL, ZD, 1'b0, 1'b0, ZD};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b0, 1'b0, 1'b1, 1'b1, 7'd0, ALL, ZD, 1'b1, 1'b1, ALL};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b1, 1'b1, 7'd9, ALL, M8,
                   1'b0, 1'b1, 1'b0, 1'b0, 7'd9, ~M8, ALL, 1'b0, 1'b0, ZD};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 7'd9, ZD, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd9, ALL, ZD, 1'b0, 1'b0, ZD};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b1, 1'b0, 7'd9, ZD, ZD,
                   1'b0, 1'b1, 1'b0, 1'b1, 7'd9, ALL, ZD, 1'b1, 1'b0, M8};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 7'd9, ALL, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b1, 1'b0, 1'b0, 1'b0, 7'd9, ALL, ALL, 1'b1, 1'b1, M8};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 7'd9, ZD, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd9, ALL, ZD, 1'b0, 1'b0, ZD};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b0, 1'b0, 1'b1, 1'b1, 7'd0, ALL, ZD, 1'b1, 1'b0, M8};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'd3, ZD, ZD, 1'b1, 1'b0, 7'd5, ZD, ZD,
                   1'b1, 1'b0, 1'b0, 1'b1, 7'd3, ALL, ZD, 1'b0, 1'b0, ZD};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b0, 1'b0, 7'd0, ZD, ZD,
                   1'b0, 1'b0, 1'b1, 1'b1, 7'd0, ALL, ZD, 1'b1, 1'b0, ZD};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 7'd0, ZD, ZD, 1'b1, 1'b0, 7'd7, ZD, ZD,
                   1'b0, 1'b0, 1'b1, 1'b1, 7'd0, ALL, ZD, 1'b0, 1'b0, ZD};

      setIdle();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sampleCycle();
         finishCycle();
      end

      // Sweep after reset with both requesters already waiting.
      $display("[TB] init sweep with both requesters pending");
      rst = 1'b0;
      bus.p0_req = 1'b1;
      bus.p0_addr = 7'd1;
      bus.p1_req = 1'b1;
      bus.p1_addr = 7'd2;
      busy_n = 0;
      gnt_in_init = 0;
      for (int c = 0; c < 300; c++) begin
         sampleCycle();
         if (!bus.init_busy) break;
         busy_n++;
         if (!sram_cen && !sram_gwen && sram_wen == ZD && sram_d == ZD) seen[sram_a]++;
         if (bus.p0_gnt || bus.p1_gnt) gnt_in_init++;
         finishCycle();
      end
      ones = 0;
      for (int i = 0; i < NENT; i++) if (seen[i] == 1) ones++;
      checkOutput("init_len", 64'(busy_n), 64'(NENT));
      checkOutput("gnt_during_init", 64'(gnt_in_init), 64'd0);
      checkOutput("sweep_each_once", 64'(ones), 64'(NENT));

      streak = 0;
      max_streak = 0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) sampleCycle();
         checkOutput($sformatf("pattern_p1_%0d", k), 64'(bus.p1_gnt), 64'(k % 5 == 0));
         checkOutput($sformatf("pattern_p0_%0d", k), 64'(bus.p0_gnt), 64'(k % 5 != 0));
         if (bus.p1_gnt) streak = 0;
         else streak++;
         if (streak > max_streak) max_streak = streak;
         finishCycle();
      end
      checkOutput("p1_max_wait", 64'(max_streak <= STARVE_LIM), 64'd1);

      setIdle();
      for (int i = 0; i < 2; i++) begin
         sampleCycle();
         finishCycle();
      end

      $display("[TB] vector table");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         sampleCycle();
         checkOutput($sformatf("v%0d_p0_gnt", i), 64'(bus.p0_gnt), 64'(vecs[i].x_g0));
         checkOutput($sformatf("v%0d_p1_gnt", i), 64'(bus.p1_gnt), 64'(vecs[i].x_g1));
         checkOutput($sformatf("v%0d_cen", i), 64'(sram_cen), 64'(vecs[i].x_cen));
         checkOutput($sformatf("v%0d_gwen", i), 64'(sram_gwen), 64'(vecs[i].x_gwen));
         checkOutput($sformatf("v%0d_a", i), 64'(sram_a), 64'(vecs[i].x_a));
         checkOutput($sformatf("v%0d_wen", i), 64'(sram_wen), 64'(vecs[i].x_wen));
         checkOutput($sformatf("v%0d_d", i), 64'(sram_d), 64'(vecs[i].x_d));
         checkOutput($sformatf("v%0d_rd_vld", i), 64'(bus.rd_vld), 64'(vecs[i].x_rvld));
         if (vecs[i].x_rvld) begin
            checkOutput($sformatf("v%0d_rd_src", i), 64'(bus.rd_src), 64'(vecs[i].x_rsrc));
            checkOutput($sformatf("v%0d_rd_data", i), 64'(bus.rd_data), 64'(vecs[i].x_rdata));
         end
         finishCycle();
      end

      // The last vector pulsed inv_all_req: expect a fresh 128-cycle sweep, then all-zero readback.
      setIdle();
      busy_n = 0;
      for (int c = 0; c < 300; c++) begin
         sampleCycle();
         if (!bus.init_busy) break;
         busy_n++;
         finishCycle();
      end
      checkOutput("inv_sweep_len", 64'(busy_n), 64'(NENT));
      finishCycle();
      vld_n = 0;
      nz_n = 0;
      for (int i = 0; i <= NENT; i++) begin
         if (i < NENT) begin
            bus.p1_req = 1'b1;
            bus.p1_addr = AW'(i);
         end else begin
            setIdle();
         end
         sampleCycle();
         if (bus.rd_vld) begin
            vld_n++;
            if (bus.rd_data !== ZD) nz_n++;
         end
         finishCycle();
      end
      checkOutput("readback_vld_count", 64'(vld_n), 64'(NENT));
      checkOutput("readback_nonzero", 64'(nz_n), 64'd0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 600; c++) begin
         applyRandom();
         rst = ($urandom_range(299) == 0);
         sampleCycle();
         finishCycle();
      end
      rst = 1'b0;
      setIdle();

      $display("[TB] reset in the middle of a sweep and of a read");
      for (int c = 0; c < 300; c++) begin
         sampleCycle();
         if (!bus.init_busy) break;
         finishCycle();
      end
      checkOutput("idle_before_reset_test", 64'(bus.init_busy), 64'd0);
      finishCycle();
      bus.inv_all_req = 1'b1;
      sampleCycle();
      finishCycle();
      bus.inv_all_req = 1'b0;
      for (int k = 0; k < 60; k++) begin
         sampleCycle();
         finishCycle();
      end
      rst = 1'b1;
      sampleCycle();
      checkOutput("sweep_at_reset", 64'(sram_a), 64'd60);
      finishCycle();
      rst = 1'b0;
      busy_n = 0;
      vld_n = 0;
      for (int c = 0; c < 300; c++) begin
         sampleCycle();
         if (c == 0) checkOutput("restart_addr", 64'(sram_a), 64'd0);
         if (!bus.init_busy) break;
         busy_n++;
         if (bus.rd_vld) vld_n++;
         finishCycle();
      end
      checkOutput("restart_len", 64'(busy_n), 64'(NENT));
      checkOutput("rd_vld_during_sweep", 64'(vld_n), 64'd0);
      finishCycle();

      bus.p1_req = 1'b1;
      bus.p1_addr = 7'd4;
      rst = 1'b1;
      sampleCycle();
      finishCycle();
      rst = 1'b0;
      setIdle();
      sampleCycle();
      checkOutput("rd_vld_after_reset", 64'(bus.rd_vld), 64'd0);
      checkOutput("busy_after_reset", 64'(bus.init_busy), 64'd1);
      finishCycle();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/pa_spsram_128x42_ctrl.md
Name: pa_spsram_128x42_ctrl

Overview:
Access controller for the 128x42 single-port SRAM in the LSU.
- After reset, and on request, it runs an init sweep that zeroes all 128 entries.
- It arbitrates two requesters onto the single port: p0 is refill (high priority) and p1 is the LSU pipeline (low priority, with a starvation guard).
- It returns read data with one-cycle latency, tagged with the source requester.

Parameters:
ADDR_WIDTH, 7, SRAM address width; entry count = 2^ADDR_WIDTH.
DATA_WIDTH, 42, SRAM data and bit-mask width.
STARVE_LIM, 4, consecutive p1 losses after which p1 is granted once over p0.

Ports:
forever_cpuclk  in  1  clock.
cpurst  in  1  reset; synchronous, active-high.
inv_all_req  in  1  one-cycle pulse requesting an init sweep.
init_busy  out  1  sweep in progress.
p0_req  in  1  refill request valid.
p0_wr  in  1  1 = write, 0 = read.
p0_addr  in  ADDR_WIDTH  entry address.
p0_wdata  in  DATA_WIDTH  write data.
p0_wmask  in  DATA_WIDTH  per-bit write enable, 1 = write.
p0_gnt  out  1  request accepted this cycle.
p1_req / p1_wr / p1_addr / p1_wdata / p1_wmask / p1_gnt  as p0, for the LSU.
rd_vld  out  1  read data valid.
rd_src  out  1  source of the read: 0 = p0, 1 = p1.
rd_data  out  DATA_WIDTH  read data.
sram_a  out  ADDR_WIDTH  SRAM A.
sram_cen  out  1  SRAM CEN, active-low.
sram_gwen  out  1  SRAM GWEN, active-low.
sram_wen  out  DATA_WIDTH  SRAM WEN, active-low per bit.
sram_d  out  DATA_WIDTH  SRAM D.
sram_q  in  DATA_WIDTH  SRAM Q, valid the cycle after a read.

Behaviour:
- Clock and reset: single clock forever_cpuclk. cpurst is synchronous and active-high.
- Reset state on the cycle after cpurst is sampled high:
  - state = INIT, sweep_cnt = 0, starve_cnt = 0.
  - rd_vld = 0, rd_src = 0.
  - init_busy = 1, both grants = 0.
- Reset asserted mid-sweep or mid-read restarts the sweep from entry 0 and drops any pending rd_vld.
- FSM states are IDLE and INIT.
- INIT state:
  - Drive sram_cen = 0, sram_gwen = 0, sram_wen = all 0, sram_d = 0, sram_a = sweep_cnt.
  - sweep_cnt increments every cycle.
  - When sweep_cnt == 127: go to IDLE and clear sweep_cnt. A full sweep takes exactly 128 cycles.
  - p0_gnt and p1_gnt are held at 0.
  - inv_all_req is ignored; there is no restart.
- IDLE state:
  - init_busy = 0.
  - If inv_all_req = 1: go to INIT next cycle, no grant this cycle, SRAM idle.
  - Otherwise arbitrate.
- Arbitration (combinational, same-cycle grant; a request is accepted iff its gnt = 1):
  - Only p0 requests: grant p0.
  - Only p1 requests: grant p1.
  - Both request and starve_cnt < STARVE_LIM: grant p0, starve_cnt += 1.
  - Both request and starve_cnt == STARVE_LIM: grant p1.
  - starve_cnt resets to 0 on any p1 grant. starve_cnt is unchanged when p1 is not requesting.
- SRAM drive for the granted request (combinational from the grant mux; the SRAM registers on the clock edge):
  - sram_cen = 0, sram_a = addr.
  - Write: sram_gwen = 0, sram_wen = ~wmask, sram_d = wdata.
  - Read: sram_gwen = 1, sram_wen = all 1, sram_d = 0.
  - A write with wmask = 0 is still issued (gwen = 0) and changes nothing.
- No grant: sram_cen = 1, sram_gwen = 1, sram_wen = all 1, sram_a = 0, sram_d = 0.
- Read return:
  - rd_vld and rd_src are registered and assert one cycle after a read grant.
  - rd_data = sram_q passthrough, valid only while rd_vld = 1.
  - Back-to-back reads give a continuous rd_vld.
  - A read to address X granted the cycle after a write to X returns the new data.

Decomposition:
- Shared package pa_lsu_sram_pkg: ADDR_WIDTH and DATA_WIDTH constants, FSM state encoding (IDLE = 1'b0, INIT = 1'b1), and a request struct {wr, addr, wdata, wmask}.
- One natural sub-module: pa_spsram_arb2, the two-way fixed-priority arbiter with starvation counter. It outputs grants and the selected request.
- The top level holds the FSM, sweep counter, SRAM drive mux and read-return register, and instantiates pa_spsram_128x42 in the bench only.

Test Plan:
- Reset, then hold both reqs high -> init_busy = 1 for exactly 128 cycles; addresses 0..127 are each written once with all-zero data and mask; first grant (p0) on cycle 129.
- After init, p0 writes addr 5 = 42'h3FF_FFFF_FFFF with mask all-1, then p1 reads addr 5 -> rd_vld = 1, rd_src = 1, rd_data = 42'h3FF_FFFF_FFFF one cycle after the p1 grant.
- Partial write to addr 9: mask = 42'h0FF, data = 42'h3FF_FFFF_FFFF on an entry holding 0, then read -> rd_data = 42'h0FF.
- p0 and p1 request continuously -> grant pattern p0,p0,p0,p0,p1 repeating; p1 is never starved beyond 4 cycles.
- inv_all_req pulsed while p1_req = 1 in IDLE -> p1_gnt = 0 that cycle, then 128 INIT cycles, then all entries read back 0.
- cpurst asserted at sweep_cnt = 60 for one cycle -> sweep restarts at address 0 and completes 128 cycles later; rd_vld stays 0 throughout.
